// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage load/store engine: size codes, FSM
// states and the byte-lane strobe mask helper.
package mem_pkg;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_D = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

    // Lanes off .. off+n-1 set; bits above the bus width flag a spilling access.
    function automatic logic [7:0] strobe_mask(input logic [1:0] size, input logic [2:0] off);
        logic [15:0] w_mask;
        w_mask = ((16'd1 << (5'd1 << size)) - 16'd1) << off;
        return w_mask[7:0];
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store strobes and replication, misalignment
// detection, and load extraction with sign/zero extension.
module mem_lane_align import mem_pkg::*; #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0]                       i_addr_lo,
    input  logic [1:0]                       i_size,
    input  logic [DATA_WIDTH-1:0]            i_wdata,
    input  logic [$clog2(DATA_WIDTH/8)-1:0]  i_ld_off,
    input  logic [1:0]                       i_ld_size,
    input  logic                             i_ld_sign,
    input  logic [DATA_WIDTH-1:0]            i_rdata,
    output logic [DATA_WIDTH/8-1:0]          o_strobe,
    output logic [DATA_WIDTH-1:0]            o_wdata_rep,
    output logic                             o_misaligned,
    output logic [DATA_WIDTH-1:0]            o_load_data
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFFW  = $clog2(BYTES);

    logic [2:0]            w_align_mask;
    logic [2:0]            w_off3;
    logic [7:0]            w_mask8;
    logic [DATA_WIDTH-1:0] w_shift;
    logic [DATA_WIDTH-1:0] w_keep;
    logic                  w_msb;

    // Strobes and misalignment; a mask spilling past the bus means n > BYTES.
    always_comb begin
        w_off3 = 3'(i_addr_lo[OFFW-1:0]);
        w_mask8 = strobe_mask(i_size, w_off3);
        case (i_size)
            SIZE_B:  w_align_mask = 3'b000;
            SIZE_H:  w_align_mask = 3'b001;
            SIZE_W:  w_align_mask = 3'b011;
            default: w_align_mask = 3'b111;
        endcase
        o_strobe     = w_mask8[BYTES-1:0];
        o_misaligned = (|(i_addr_lo & w_align_mask)) | (|(w_mask8 >> BYTES));
    end

    // Replicate the low n bytes of store data across every lane.
    always_comb begin
        o_wdata_rep = '0;
        for (int i = 0; i < BYTES; i++) begin
            case (i_size)
                SIZE_B:  o_wdata_rep[8*i +: 8] = i_wdata[7:0];
                SIZE_H:  o_wdata_rep[8*i +: 8] = i_wdata[8*(i%2) +: 8];
                SIZE_W:  o_wdata_rep[8*i +: 8] = i_wdata[8*(i%4) +: 8];
                default: o_wdata_rep[8*i +: 8] = i_wdata[8*(i%8) +: 8];
            endcase
        end
    end

    // Shift the addressed lanes down, keep n bytes, extend from their top bit.
    always_comb begin
        w_shift = i_rdata >> {i_ld_off, 3'b000};
        case (i_ld_size)
            SIZE_B: begin
                w_keep = DATA_WIDTH'(64'h0000_0000_0000_00FF);
                w_msb  = w_shift[7];
            end
            SIZE_H: begin
                w_keep = DATA_WIDTH'(64'h0000_0000_0000_FFFF);
                w_msb  = w_shift[15];
            end
            SIZE_W: begin
                w_keep = DATA_WIDTH'(64'h0000_0000_FFFF_FFFF);
                w_msb  = w_shift[31];
            end
            default: begin
                w_keep = '1;
                w_msb  = w_shift[DATA_WIDTH-1];
            end
        endcase
        o_load_data = (w_shift & w_keep) | ({DATA_WIDTH{i_ld_sign & w_msb}} & ~w_keep);
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: issues one registered byte-lane RAM access per
// request, stalls the pipeline until ready or timeout, and returns load data.
module mem_access_unit import mem_pkg::*; #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mem_valid,
    input  logic                    mem_read_flag,
    input  logic                    mem_write_flag,
    input  logic                    mem_sign_ext_flag,
    input  logic [1:0]              mem_size,
    input  logic [ADDR_WIDTH-1:0]   mem_addr,
    input  logic [DATA_WIDTH-1:0]   mem_write_data,
    input  logic                    flush,
    output logic                    stall_req,
    output logic [DATA_WIDTH-1:0]   load_data,
    output logic                    load_valid,
    output logic                    addr_error,
    output logic                    bus_error,
    output logic [ADDR_WIDTH-1:0]   bad_addr,
    output logic                    ram_en,
    output logic [DATA_WIDTH/8-1:0] ram_write_en,
    output logic [ADDR_WIDTH-1:0]   ram_addr,
    output logic [DATA_WIDTH-1:0]   ram_write_data,
    input  logic [DATA_WIDTH-1:0]   ram_read_data,
    input  logic                    ram_ready
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFFW  = $clog2(BYTES);
    localparam int CW    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    mem_state_e             r_state, w_next;
    logic [CW-1:0]          r_cnt;
    logic                   r_discard, r_is_read, r_ld_sign;
    logic [OFFW-1:0]        r_ld_off;
    logic [1:0]             r_ld_size;
    logic                   r_ram_en, r_load_valid, r_bus_error;
    logic [BYTES-1:0]       r_ram_we;
    logic [ADDR_WIDTH-1:0]  r_ram_addr, r_bad_addr;
    logic [DATA_WIDTH-1:0]  r_ram_wdata, r_load_data;

    logic                   w_access, w_issue, w_fault, w_complete, w_timeout;
    logic [BYTES-1:0]       w_strobe;
    logic [DATA_WIDTH-1:0]  w_wdata_rep, w_load_ext;
    logic                   w_misaligned;

    mem_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .i_addr_lo    (mem_addr[2:0]),
        .i_size       (mem_size),
        .i_wdata      (mem_write_data),
        .i_ld_off     (r_ld_off),
        .i_ld_size    (r_ld_size),
        .i_ld_sign    (r_ld_sign),
        .i_rdata      (ram_read_data),
        .o_strobe     (w_strobe),
        .o_wdata_rep  (w_wdata_rep),
        .o_misaligned (w_misaligned),
        .o_load_data  (w_load_ext)
    );

    assign w_access = mem_valid & (mem_read_flag | mem_write_flag);

    // Next-state logic and the per-cycle events that drive the datapath.
    always_comb begin
        w_next     = r_state;
        w_issue    = 1'b0;
        w_fault    = 1'b0;
        w_complete = 1'b0;
        w_timeout  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_access && !flush) begin
                    if (w_misaligned) begin
                        w_fault = 1'b1;
                    end else begin
                        w_issue = 1'b1;
                        w_next  = ST_WAIT;
                    end
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (ram_ready) begin
                    w_complete = 1'b1;
                    w_next     = ST_DONE;
                end else if ((TIMEOUT_CYCLES != 0) && (r_cnt == TO_LAST)) begin
                    w_timeout = 1'b1;
                    w_next    = ST_DONE;
                end else begin
                    w_next = ST_WAIT;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Gated by reset so every output reads zero while reset is asserted.
    assign stall_req  = rst & (w_issue | (r_state == ST_WAIT));
    assign addr_error = rst & w_fault;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next;
    end

    // Bus-side registers, timeout counter, discard flag and result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt        <= '0;
            r_discard    <= 1'b0;
            r_is_read    <= 1'b0;
            r_ld_off     <= '0;
            r_ld_size    <= SIZE_B;
            r_ld_sign    <= 1'b0;
            r_ram_en     <= 1'b0;
            r_ram_we     <= '0;
            r_ram_addr   <= '0;
            r_ram_wdata  <= '0;
            r_load_data  <= '0;
            r_load_valid <= 1'b0;
            r_bus_error  <= 1'b0;
            r_bad_addr   <= '0;
        end else begin
            r_load_valid <= 1'b0;
            r_bus_error  <= 1'b0;
            if (w_fault) r_bad_addr <= mem_addr;
            if (w_issue) begin
                r_ram_en    <= 1'b1;
                r_ram_we    <= mem_write_flag ? w_strobe : '0;
                r_ram_addr  <= {mem_addr[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};
                r_ram_wdata <= w_wdata_rep;
                r_is_read   <= ~mem_write_flag;
                r_ld_off    <= mem_addr[OFFW-1:0];
                r_ld_size   <= mem_size;
                r_ld_sign   <= mem_sign_ext_flag;
                r_discard   <= 1'b0;
                r_cnt       <= '0;
            end
            if (r_state == ST_WAIT) begin
                r_cnt <= r_cnt + 1'b1;
                if (flush) r_discard <= 1'b1;
            end
            if (w_complete) begin
                r_ram_en <= 1'b0;
                r_ram_we <= '0;
                // A flush arriving on the ready cycle also discards the result.
                if (r_is_read && !r_discard && !flush) begin
                    r_load_data  <= w_load_ext;
                    r_load_valid <= 1'b1;
                end
            end
            if (w_timeout) begin
                r_ram_en    <= 1'b0;
                r_ram_we    <= '0;
                r_bus_error <= 1'b1;
                r_bad_addr  <= r_ram_addr;
                r_load_data <= '0;
            end
            if (r_state == ST_DONE) begin
                r_discard <= 1'b0;
                r_cnt     <= '0;
            end
        end
    end

    assign load_data      = r_load_data;
    assign load_valid     = r_load_valid;
    assign bus_error      = r_bus_error;
    assign bad_addr       = r_bad_addr;
    assign ram_en         = r_ram_en;
    assign ram_write_en   = r_ram_we;
    assign ram_addr       = r_ram_addr;
    assign ram_write_data = r_ram_wdata;

endmodule
